// File: rtl/audio_codec_pkg.sv
// Shared types and defaults for the audio codec serial interface.
package audio_codec_pkg;
   localparam int DEFAULT_BCLK_DIV  = 32;
   localparam int DEFAULT_SLOT_BITS = 16;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } channel_e;
endpackage

// File: rtl/audio_bclk_gen.sv
// Bit clock divider: toggles bclk every BCLK_DIV clks and flags each edge
// one clk ahead so the slot logic can act on the same clk edge.
module audio_bclk_gen
   import audio_codec_pkg::*;
#(
   parameter int BCLK_DIV = DEFAULT_BCLK_DIV
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_bclk,
   output logic o_rise_evt,
   output logic o_fall_evt
);
   localparam int DW = $clog2(BCLK_DIV);
   localparam logic [DW-1:0] LAST = DW'(BCLK_DIV - 1);

   logic [DW-1:0] r_div_cnt;
   logic          r_bclk;
   logic          w_wrap;

   assign w_wrap = (r_div_cnt == LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div_cnt <= '0;
         r_bclk    <= 1'b0;
      end else if (w_wrap) begin
         r_div_cnt <= '0;
         r_bclk    <= ~r_bclk;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   assign o_bclk     = r_bclk;
   assign o_rise_evt = w_wrap & ~r_bclk;
   assign o_fall_evt = w_wrap & r_bclk;
endmodule

// File: rtl/audio_codec_i2s.sv
// Left-justified codec serial port: drives bclk/lrck, shifts DAC words out
// MSB-first and assembles ADC words, with one-clk request/complete strobes.
module audio_codec_i2s
   import audio_codec_pkg::*;
#(
   parameter int BCLK_DIV  = DEFAULT_BCLK_DIV,
   parameter int SLOT_BITS = DEFAULT_SLOT_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 sample_req,
   input  logic [SLOT_BITS-1:0] audio_output,
   output logic                 sample_end,
   output logic [SLOT_BITS-1:0] audio_input,
   output logic                 channel_sel,
   output logic                 aud_bclk,
   output logic                 aud_lrck,
   output logic                 aud_dacdat,
   input  logic                 aud_adcdat
);
   localparam int BW = $clog2(SLOT_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(SLOT_BITS - 1);
   localparam logic [BW-1:0] PEN_BIT  = BW'(SLOT_BITS - 2);

   logic                 w_rise;
   logic                 w_fall;
   logic [SLOT_BITS-1:0] w_adc_word;

   logic [BW-1:0]        r_bit_cnt;
   logic                 r_lrck;
   logic [SLOT_BITS-1:0] r_dac_shift;
   logic [SLOT_BITS-2:0] r_adc_shift;
   logic [SLOT_BITS-1:0] r_next_word;
   logic [SLOT_BITS-1:0] r_audio_in;
   logic                 r_req;
   logic                 r_req_d;
   logic                 r_end;
   channel_e             r_chan;

   audio_bclk_gen #(
      .BCLK_DIV (BCLK_DIV)
   ) u_bclk (
      .i_clk      (clk),
      .i_rst      (reset),
      .o_bclk     (aud_bclk),
      .o_rise_evt (w_rise),
      .o_fall_evt (w_fall)
   );

   assign w_adc_word = {r_adc_shift, aud_adcdat};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bit_cnt   <= '0;
         r_lrck      <= 1'b0;
         r_dac_shift <= '0;
         r_adc_shift <= '0;
         r_next_word <= '0;
         r_audio_in  <= '0;
         r_req       <= 1'b0;
         r_req_d     <= 1'b0;
         r_end       <= 1'b0;
         r_chan      <= CH_LEFT;
      end else begin
         r_req   <= w_fall && (r_bit_cnt == PEN_BIT);
         r_req_d <= r_req;
         r_end   <= w_rise && (r_bit_cnt == LAST_BIT);
         // audio_effects answers the request one clk later
         if (r_req_d)
            r_next_word <= audio_output;
         if (w_fall) begin
            if (r_bit_cnt == LAST_BIT) begin
               r_bit_cnt   <= '0;
               r_lrck      <= ~r_lrck;
               r_dac_shift <= r_next_word;
            end else begin
               r_bit_cnt   <= r_bit_cnt + 1'b1;
               r_dac_shift <= {r_dac_shift[SLOT_BITS-2:0], 1'b0};
            end
            if (r_bit_cnt == PEN_BIT)
               r_chan <= channel_e'(~r_lrck);
         end
         if (w_rise) begin
            r_adc_shift <= w_adc_word[SLOT_BITS-2:0];
            if (r_bit_cnt == LAST_BIT) begin
               r_audio_in <= w_adc_word;
               r_chan     <= channel_e'(r_lrck);
            end
         end
      end
   end

   assign sample_req  = r_req;
   assign sample_end  = r_end;
   assign audio_input = r_audio_in;
   assign channel_sel = r_chan;
   assign aud_lrck    = r_lrck;
   assign aud_dacdat  = r_dac_shift[SLOT_BITS-1];
endmodule

// File: tb/tb_audio_codec_i2s.sv
// Bench for audio_codec_i2s: a codec-side model drives ADC bits, feeds DAC
// words on request and reassembles the serial streams into slot words.
module tb_audio_codec_i2s;
   localparam int DIV = 4;
   localparam int SB  = 16;

   typedef struct {
      logic [15:0] adc_l;
      logic [15:0] adc_r;
      logic [15:0] dac_l;
      logic [15:0] dac_r;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          sample_req;
   logic [SB-1:0] audio_output = '0;
   logic          sample_end;
   logic [SB-1:0] audio_input;
   logic          channel_sel;
   logic          aud_bclk;
   logic          aud_lrck;
   logic          aud_dacdat;
   logic          aud_adcdat = 1'b0;

   int ncmp = 0;
   int nerr = 0;
   int n_req = 0;
   int n_end = 0;

   logic [15:0] adc_w   [64];
   logic [15:0] dac_w   [64];
   logic [15:0] got_adc [64];
   logic [15:0] got_dac [64];
   vec_t        tbl     [4];

   audio_codec_i2s #(
      .BCLK_DIV  (DIV),
      .SLOT_BITS (SB)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_req   (sample_req),
      .audio_output (audio_output),
      .sample_end   (sample_end),
      .audio_input  (audio_input),
      .channel_sel  (channel_sel),
      .aud_bclk     (aud_bclk),
      .aud_lrck     (aud_lrck),
      .aud_dacdat   (aud_dacdat),
      .aud_adcdat   (aud_adcdat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_got();
      for (int i = 0; i < 64; i++) begin
         got_adc[i] = 'x;
         got_dac[i] = 'x;
      end
   endtask

   // Codec ADC side: each bclk fall presents the next bit, MSB first,
   // slot n carrying adc_w[n].
   initial begin
      int  fidx;
      logic pb;
      fidx = 0;
      pb   = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            fidx = 0;
            pb   = 1'b0;
         end else begin
            if (pb && !aud_bclk) fidx++;
            pb = aud_bclk;
         end
         aud_adcdat = adc_w[(fidx / 16) % 64][15 - (fidx % 16)];
      end
   end

   // Codec DAC side: sample dacdat on each bclk rise, 16 bits per slot.
   initial begin
      int          ridx;
      int          s;
      int          b;
      logic        pb;
      logic [15:0] w;
      ridx = 0;
      pb   = 1'b0;
      w    = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            ridx = 0;
            pb   = 1'b0;
         end else begin
            if (!pb && aud_bclk) begin
               s = ridx / 16;
               b = ridx % 16;
               if (b == 0)
                  chk("lrck_align", 32'(aud_lrck), 32'(s % 2));
               w = {w[14:0], aud_dacdat};
               if (b == 15 && s < 64) got_dac[s] = w;
               ridx++;
            end
            pb = aud_bclk;
         end
      end
   end

   // sample_end consumer: slot e completes with channel e%2.
   initial begin
      int   e;
      logic pe;
      e  = 0;
      pe = 1'b0;
      forever begin
         @(negedge clk);
         if (sample_end) n_end++;
         if (reset) begin
            e  = 0;
            pe = 1'b0;
         end else begin
            if (sample_end) begin
               chk("end_width", 32'(pe), 32'(0));
               chk("end_req_overlap", 32'(sample_req), 32'(0));
               chk("end_chan", 32'(channel_sel), 32'(e % 2));
               if (e < 64) got_adc[e] = audio_input;
               e++;
            end
            pe = sample_end;
         end
      end
   end

   // audio_effects stand-in: valid word only in the capture cycle,
   // noise on audio_output at every other time.
   initial begin
      int k;
      k = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            k = 0;
            audio_output = 16'($urandom);
         end else if (sample_req) begin
            chk("req_chan", 32'(channel_sel), 32'((k + 1) % 2));
            chk("req_end_overlap", 32'(sample_end), 32'(0));
            n_req++;
            @(posedge clk);
            #1;
            chk("req_width", 32'(sample_req), 32'(0));
            audio_output = dac_w[(k + 1) % 64];
            @(posedge clk);
            #1;
            audio_output = 16'($urandom);
            k++;
         end else begin
            audio_output = 16'($urandom);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   t_b1;
      int   t_b2;
      int   t_l1;
      int   t_l2;
      int   nr10;
      int   ne10;
      int   n0;
      int   nr;
      logic pb;
      logic pl;

      tbl[0] = '{16'h1234, 16'hFEDC, 16'h0000, 16'hA55A};
      tbl[1] = '{16'h0000, 16'hFFFF, 16'hA55A, 16'hA55A};
      tbl[2] = '{16'hAAAA, 16'h5555, 16'h8001, 16'h7FFE};
      tbl[3] = '{16'h8000, 16'h0001, 16'hFFFF, 16'h0000};
      for (int f = 0; f < 4; f++) begin
         adc_w[2*f]   = tbl[f].adc_l;
         adc_w[2*f+1] = tbl[f].adc_r;
         dac_w[2*f]   = tbl[f].dac_l;
         dac_w[2*f+1] = tbl[f].dac_r;
      end
      for (int s = 8; s < 64; s++) begin
         adc_w[s] = 16'($urandom);
         dac_w[s] = 16'($urandom);
      end
      clear_got();

      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_ctrl", 32'({sample_req, sample_end, channel_sel,
          aud_bclk, aud_lrck, aud_dacdat}), 32'(0));
      chk("reset_audio_input", 32'(audio_input), 32'(0));

      n_req = 0;
      n_end = 0;
      t_b1 = -1; t_b2 = -1; t_l1 = -1; t_l2 = -1;
      nr10 = -1; ne10 = -1;
      pb = 1'b0;
      pl = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      for (int cyc = 1; cyc <= 16 * 256; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc == 3)
            chk("pre_bclk_outs", 32'({sample_req, sample_end, channel_sel,
                aud_bclk, aud_lrck, aud_dacdat, audio_input}), 32'(0));
         if (aud_bclk && !pb) begin
            if (t_b1 < 0) t_b1 = cyc;
            else if (t_b2 < 0) t_b2 = cyc;
         end
         if (aud_lrck && !pl) begin
            if (t_l1 < 0) t_l1 = cyc;
            else if (t_l2 < 0) t_l2 = cyc;
         end
         pb = aud_bclk;
         pl = aud_lrck;
         if (cyc == 2562) begin
            nr10 = n_req;
            ne10 = n_end;
         end
      end
      chk("first_bclk_rise", 32'(t_b1), 32'(DIV));
      chk("bclk_period", 32'(t_b2 - t_b1), 32'(2 * DIV));
      chk("first_lrck_rise", 32'(t_l1), 32'(SB * 2 * DIV));
      chk("lrck_period", 32'(t_l2 - t_l1), 32'(2 * SB * 2 * DIV));
      chk("req_count_10fr", 32'(nr10), 32'(20));
      chk("end_count_10fr", 32'(ne10), 32'(20));

      for (int f = 0; f < 4; f++) begin
         chk($sformatf("tbl%0d_adc_l", f), 32'(got_adc[2*f]), 32'(tbl[f].adc_l));
         chk($sformatf("tbl%0d_adc_r", f), 32'(got_adc[2*f+1]), 32'(tbl[f].adc_r));
         chk($sformatf("tbl%0d_dac_l", f), 32'(got_dac[2*f]), 32'(tbl[f].dac_l));
         chk($sformatf("tbl%0d_dac_r", f), 32'(got_dac[2*f+1]), 32'(tbl[f].dac_r));
      end
      for (int s = 8; s < 32; s++) begin
         chk($sformatf("rnd_adc_s%0d", s), 32'(got_adc[s]), 32'(adc_w[s]));
         chk($sformatf("rnd_dac_s%0d", s), 32'(got_dac[s]), 32'(dac_w[s]));
      end

      for (int i = 0; i < 600 && !aud_lrck; i++) @(negedge clk);
      chk("wait_right_slot", 32'(aud_lrck), 32'(1));
      nr = 0;
      pb = aud_bclk;
      for (int i = 0; i < 200 && nr < 8; i++) begin
         @(negedge clk);
         if (aud_bclk && !pb) nr++;
         pb = aud_bclk;
      end
      chk("wait_bit7", 32'(nr), 32'(8));
      #2 reset = 1'b1;
      #1;
      chk("async_lrck", 32'(aud_lrck), 32'(0));
      chk("async_bclk", 32'(aud_bclk), 32'(0));
      chk("async_outs", 32'({sample_req, sample_end, channel_sel,
          aud_dacdat, audio_input}), 32'(0));
      n0 = n_end;
      repeat (2) @(negedge clk);
      clear_got();
      repeat (8) @(negedge clk);
      #2 reset = 1'b0;
      repeat (100) @(posedge clk);
      chk("no_partial_end", 32'(n_end - n0), 32'(0));
      repeat (200) @(posedge clk);
      #1;
      chk("restart_dac_left0", 32'(got_dac[0]), 32'(16'h0000));
      chk("restart_dac_right", 32'(got_dac[1]), 32'(dac_w[1]));
      chk("restart_adc_left", 32'(got_adc[0]), 32'(adc_w[0]));
      chk("restart_adc_right", 32'(got_adc[1]), 32'(adc_w[1]));

      $display("End of test - %0d assertions evaluated, %0d failures",
               ncmp, nerr);
      $finish;
   end
endmodule
